// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the dmem data memory slice.
//   XLEN / STRB_W : data word width and byte-strobe width
//   dmem_state_e  : request FSM state encoding (IDLE, WAIT, RESP)
//   strb_fits     : store strobe lies inside one aligned halfword or is a full word
//   access_fault  : fault rule applied when DMEM_ERR_CHECK_EN is defined
package dmem_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // An empty strobe is a legal no-op; otherwise every enabled lane must sit in
  // the same aligned halfword, or the strobe must cover the whole word.
  function automatic logic strb_fits(input logic [STRB_W-1:0] strb);
    logic ok;
    case (strb)
      4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Out of range, misaligned load, or a store strobe straddling halfwords.
  function automatic logic access_fault(input logic              wr,
                                        input logic [XLEN-1:0] addr,
                                        input logic [STRB_W-1:0] strb,
                                        input int unsigned     depth);
    logic oob;
    logic mis;
    oob = (addr >= (32'(depth) << 2));
    if (wr) begin
      mis = !strb_fits(strb);
    end else begin
      mis = (addr[1:0] != 2'b00);
    end
    return oob | mis;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if -- request/response channel between an initiator and dmem.
//   request : req_valid, req_ready, req_write, req_addr, req_wdata, req_wstrb
//   response: resp_valid, resp_ready, resp_rdata, resp_err
//   modports: master (initiator side), slave (memory side)
interface dmem_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_array.sv
// dmem_array -- DEPTH x XLEN storage, one synchronous read/write port.
//   clk   : clock
//   en    : port enable; read data register updates only when set
//   we    : per-byte-lane write enables (ignored unless en)
//   addr  : word index
//   wdata : store data, lane n = bits [8n+7:8n]
//   rdata : word read on the last enabled edge (pre-write contents)
// No reset: contents survive a controller reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [STRB_W-1:0] we,
  input  logic [AW-1:0]     addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);

  logic [XLEN-1:0] mem_r [DEPTH];
  logic [XLEN-1:0] rdata_r;

  // Byte-lane write and registered read on the shared port.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (we[b]) begin
          mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dmem.sv
// dmem -- single-port data memory with a fixed-latency valid/ready protocol.
//   clk   : clock, rising edge
//   rst   : asynchronous assert, active-low reset (release synchronous to clk)
//   bus   : dmem_if.slave request/response channel
// Parameters: DEPTH (words, power of two), WAIT_CYCLES (0..15).
// Optional build macro DMEM_ERR_CHECK_EN enables range/alignment faulting;
// without it resp_err is 0 and addresses wrap modulo 4*DEPTH.
module dmem
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_e       state_r, state_s;
  logic [3:0]        cnt_r;
  logic              req_ready_r, resp_valid_r, resp_err_r, resp_load_r;

  // request captured on accept
  logic              wr_r, fault_r;
  logic [AW-1:0]     idx_r;
  logic [XLEN-1:0]   wdata_r;
  logic [STRB_W-1:0] wstrb_r;

  logic              accept_s, access_s, live_fault_s;
  logic              acc_write_s, acc_fault_s;
  logic [AW-1:0]     acc_idx_s;
  logic [XLEN-1:0]   acc_wdata_s, rdata_s;
  logic [STRB_W-1:0] acc_wstrb_s, we_s;

  // req_ready_r is low in reset and outside IDLE, so this gates all req_* noise.
  assign accept_s = bus.req_valid & req_ready_r;

`ifdef DMEM_ERR_CHECK_EN
  assign live_fault_s = access_fault(bus.req_write, bus.req_addr, bus.req_wstrb, DEPTH);
`else
  assign live_fault_s = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ZERO_WAIT ? ST_RESP : ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // The array is touched only on the edge entering RESP; with zero wait states
  // that is the accept edge, so the live request feeds the port directly.
  always_comb begin
    access_s = (state_s == ST_RESP) && (state_r != ST_RESP);
    if (state_r == ST_IDLE) begin
      acc_write_s = bus.req_write;
      acc_fault_s = live_fault_s;
      acc_idx_s   = bus.req_addr[AW+1:2];
      acc_wdata_s = bus.req_wdata;
      acc_wstrb_s = bus.req_wstrb;
    end else begin
      acc_write_s = wr_r;
      acc_fault_s = fault_r;
      acc_idx_s   = idx_r;
      acc_wdata_s = wdata_r;
      acc_wstrb_s = wstrb_r;
    end
    if (acc_write_s && !acc_fault_s) begin
      we_s = acc_wstrb_s;
    end else begin
      we_s = 4'h0;
    end
  end

  // Control state, wait counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_load_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= (state_s == ST_IDLE);
      resp_valid_r <= (state_s == ST_RESP);
      if (accept_s) begin
        cnt_r <= WAIT_INIT;
      end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (access_s) begin
        resp_err_r  <= acc_fault_s;
        resp_load_r <= !acc_write_s && !acc_fault_s;
      end else if (state_s != ST_RESP) begin
        resp_err_r  <= 1'b0;
        resp_load_r <= 1'b0;
      end else begin
        resp_err_r  <= resp_err_r;
        resp_load_r <= resp_load_r;
      end
    end
  end

  // Request payload capture; pure datapath, qualified by accept.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      wr_r    <= bus.req_write;
      fault_r <= live_fault_s;
      idx_r   <= bus.req_addr[AW+1:2];
      wdata_r <= bus.req_wdata;
      wstrb_r <= bus.req_wstrb;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (access_s),
    .we    (we_s),
    .addr  (acc_idx_s),
    .wdata (acc_wdata_s),
    .rdata (rdata_s)
  );

  // Array output only updates on an access, so it stays stable through RESP.
  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.resp_rdata = resp_load_r ? rdata_s : 32'h0;

endmodule

// File: tb/tb_dmem.sv
// tb_dmem -- directed bench for dmem: channel 0 with WAIT_CYCLES=2, channel 1
// with WAIT_CYCLES=0, a transaction-level reference model and a per-cycle
// compare process, plus literal expectations from worked examples.
`timescale 1ns/1ps
module tb_dmem;
  import dmem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int W0    = 2;
  localparam int W1    = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  tv_valid, tv_write, tv_rr;
  logic [31:0] tv_addr [2];
  logic [31:0] tv_wdata[2];
  logic [3:0]  tv_wstrb[2];
  logic [1:0]  o_ready, o_valid, o_err;
  logic [31:0] o_rdata [2];

  dmem_if bus0();
  dmem_if bus1();

  assign bus0.req_valid  = tv_valid[0];
  assign bus0.req_write  = tv_write[0];
  assign bus0.req_addr   = tv_addr[0];
  assign bus0.req_wdata  = tv_wdata[0];
  assign bus0.req_wstrb  = tv_wstrb[0];
  assign bus0.resp_ready = tv_rr[0];
  assign o_ready[0] = bus0.req_ready;
  assign o_valid[0] = bus0.resp_valid;
  assign o_err[0]   = bus0.resp_err;
  assign o_rdata[0] = bus0.resp_rdata;

  assign bus1.req_valid  = tv_valid[1];
  assign bus1.req_write  = tv_write[1];
  assign bus1.req_addr   = tv_addr[1];
  assign bus1.req_wdata  = tv_wdata[1];
  assign bus1.req_wstrb  = tv_wstrb[1];
  assign bus1.resp_ready = tv_rr[1];
  assign o_ready[1] = bus1.req_ready;
  assign o_valid[1] = bus1.resp_valid;
  assign o_err[1]   = bus1.resp_err;
  assign o_rdata[1] = bus1.resp_rdata;

  dmem #(.DEPTH(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dmem #(.DEPTH(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (transaction level) ----------------
  logic        m_busy[2], m_rdy[2], m_err[2];
  int          m_left[2];          // edges still to go before the response shows
  logic [31:0] m_rd[2];
  logic        p_wr[2];
  logic [31:0] p_addr[2], p_wdata[2];
  logic [3:0]  p_strb[2];
  logic [31:0] m_mem[2][DEPTH];

  function automatic int wof(input int c);
    return (c == 0) ? W0 : W1;
  endfunction

  function automatic logic model_fault(input logic wr, input logic [31:0] a, input logic [3:0] s);
`ifdef DMEM_ERR_CHECK_EN
    logic in_half;
    in_half = ((s & 4'hC) == 4'h0) || ((s & 4'h3) == 4'h0) || (s == 4'hF);
    if (a >= 32'(4 * DEPTH)) return 1'b1;
    if (!wr && (a[1:0] != 2'b00)) return 1'b1;
    if (wr && !in_half) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic apply(input int c, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] s);
    logic        f;
    logic [31:0] old, nw;
    f   = model_fault(wr, a, s);
    old = m_mem[c][a[11:2]];
    if (wr) begin
      nw = old;
      for (int b = 0; b < 4; b++) if (s[b]) nw[8*b +: 8] = wd[8*b +: 8];
      if (!f) m_mem[c][a[11:2]] <= nw;
      m_rd[c] <= 32'h0;
    end else begin
      m_rd[c] <= f ? 32'h0 : old;
    end
    m_err[c] <= f;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 2; c++) begin
        m_busy[c] <= 1'b0;
        m_rdy[c]  <= 1'b0;
        m_left[c] <= 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (m_busy[c]) begin
          if (m_left[c] == 0) begin
            if (tv_rr[c]) begin
              m_busy[c] <= 1'b0;
              m_rdy[c]  <= 1'b1;
            end
          end else begin
            m_left[c] <= m_left[c] - 1;
            if (m_left[c] == 1) apply(c, p_wr[c], p_addr[c], p_wdata[c], p_strb[c]);
          end
        end else if (m_rdy[c] && tv_valid[c]) begin
          m_busy[c]  <= 1'b1;
          m_rdy[c]   <= 1'b0;
          m_left[c]  <= wof(c);
          p_wr[c]    <= tv_write[c];
          p_addr[c]  <= tv_addr[c];
          p_wdata[c] <= tv_wdata[c];
          p_strb[c]  <= tv_wstrb[c];
          if (wof(c) == 0) apply(c, tv_write[c], tv_addr[c], tv_wdata[c], tv_wstrb[c]);
        end else begin
          m_rdy[c] <= 1'b1;
        end
      end
    end
  end

  // Per-cycle compare of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 2; c++) begin
        logic ev;
        ev = m_busy[c] && (m_left[c] == 0);
        check($sformatf("ch%0d req_ready", c), 32'(o_ready[c]), 32'(m_rdy[c]));
        check($sformatf("ch%0d resp_valid", c), 32'(o_valid[c]), 32'(ev));
        check($sformatf("ch%0d resp_rdata", c), o_rdata[c], ev ? m_rd[c] : 32'h0);
        check($sformatf("ch%0d resp_err", c), 32'(o_err[c]), ev ? 32'(m_err[c]) : 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input int c, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s,
                        input int hold, input logic extra,
                        output logic [31:0] rd, output logic er, output int lat);
    int   n;
    logic acc, got;
    @(posedge clk); #1;
    tv_valid[c] = 1'b1; tv_write[c] = wr; tv_addr[c] = a;
    tv_wdata[c] = wd;   tv_wstrb[c] = s;  tv_rr[c] = 1'b0;
    n = 0; acc = 1'b0;
    while (!acc && n < 20) begin
      @(negedge clk); n++;
      if (o_ready[c]) acc = 1'b1;
    end
    if (!acc) check("accept timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    // scribble on the request lines; they must be ignored after accept
    tv_valid[c] = 1'b0; tv_addr[c] = 32'hFFFF_FFFC; tv_wdata[c] = 32'h0BAD_0BAD; tv_wstrb[c] = 4'hF;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk); lat++;
      if (o_valid[c]) got = 1'b1;
    end
    if (!got) check("resp timeout", 32'h0, 32'h1);
    rd = o_rdata[c];
    er = o_err[c];
    if (extra) begin
      tv_valid[c] = 1'b1; tv_write[c] = 1'b1; tv_addr[c] = 32'h10; tv_wdata[c] = 32'h0; tv_wstrb[c] = 4'hF;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold resp_valid", 32'(o_valid[c]), 32'h1);
      check("hold req_ready", 32'(o_ready[c]), 32'h0);
    end
    tv_rr[c] = 1'b1;
    @(posedge clk); #1;
    tv_rr[c] = 1'b0; tv_valid[c] = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          t_acc[2];
  int          nacc, guard;
  logic        saw;

  initial begin
    for (int c = 0; c < 2; c++) begin
      tv_valid[c] = 1'b0; tv_write[c] = 1'b0; tv_rr[c] = 1'b0;
      tv_addr[c] = 32'h0; tv_wdata[c] = 32'h0; tv_wstrb[c] = 4'h0;
    end
    @(posedge clk); @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst req_ready", 32'(o_ready), 32'h0);
    check("rst resp_valid", 32'(o_valid), 32'h0);
    check("rst resp_err", 32'(o_err), 32'h0);
    check("rst resp_rdata", o_rdata[0] | o_rdata[1], 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst not yet ready", 32'(o_ready), 32'h0);
    @(negedge clk);
    check("ready after release", 32'(o_ready), 32'h3);

    // store/load round trip, latency WAIT_CYCLES+1
    do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd, er, lat);
    check("store latency", 32'(lat), 32'd3);
    check("store err", 32'(er), 32'h0);
    check("store rdata", rd, 32'h0);
    // backpressure with a second request offered while busy
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1, rd, er, lat);
    check("load latency", 32'(lat), 32'd3);
    check("load 0x10", rd, 32'hDEAD_BEEF);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("load 0x10 after ignored req", rd, 32'hDEAD_BEEF);

    // byte lanes and empty strobe
    do_req(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, 1'b0, rd, er, lat);
    do_req(0, 1'b1, 32'h20, 32'h0000_00AA, 4'h1, 0, 1'b0, rd, er, lat);
    do_req(0, 1'b1, 32'h20, 32'h0000_BB00, 4'h2, 0, 1'b0, rd, er, lat);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("byte lanes 0x20", rd, 32'h1122_BBAA);
    do_req(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 0, 1'b0, rd, er, lat);
    check("wstrb0 responds", 32'(lat), 32'd3);
    do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("wstrb0 no-op", rd, 32'h1122_BBAA);

    // reset one cycle after accept aborts a pending store
    do_req(0, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 0, 1'b0, rd, er, lat);
    @(posedge clk); #1;
    tv_valid[0] = 1'b1; tv_write[0] = 1'b1; tv_addr[0] = 32'h40; tv_wdata[0] = 32'hCAFE_F00D; tv_wstrb[0] = 4'hF;
    @(negedge clk);
    check("abort accept ready", 32'(o_ready[0]), 32'h1);
    @(posedge clk); #1 tv_valid[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid-wait rst resp_valid", 32'(o_valid[0]), 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_valid[0]) saw = 1'b1;
    end
    check("aborted store no resp", 32'(saw), 32'h0);
    do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("aborted store not written", rd, 32'h1234_5678);

    // range / alignment
    do_req(0, 1'b1, 32'h0, 32'h55AA_55AA, 4'hF, 0, 1'b0, rd, er, lat);
`ifdef DMEM_ERR_CHECK_EN
    do_req(0, 1'b0, 32'h1002, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("0x1002 err", 32'(er), 32'h1);
    check("0x1002 rdata", rd, 32'h0);
    do_req(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("0x1000 err", 32'(er), 32'h1);
    check("0x1000 latency", 32'(lat), 32'd3);
    do_req(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("misaligned load err", 32'(er), 32'h1);
`else
    do_req(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("0x1000 wraps", rd, 32'h55AA_55AA);
    check("0x1000 err", 32'(er), 32'h0);
    do_req(0, 1'b0, 32'h1002, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("0x1002 wraps", rd, 32'h55AA_55AA);
    do_req(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("addr[1:0] ignored", rd, 32'hDEAD_BEEF);
`endif

    // zero wait states
    do_req(1, 1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, 0, 1'b0, rd, er, lat);
    do_req(1, 1'b1, 32'h4, 32'h5A5A_5A5A, 4'hF, 0, 1'b0, rd, er, lat);
    do_req(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
    check("w0 load latency", 32'(lat), 32'd1);
    check("w0 load 0x0", rd, 32'hA5A5_A5A5);

    // back-to-back loads with resp_ready held high
    @(posedge clk); #1;
    tv_rr[1] = 1'b1; tv_write[1] = 1'b0; tv_addr[1] = 32'h0; tv_valid[1] = 1'b1;
    nacc = 0; guard = 0;
    while (nacc < 2 && guard < 20) begin
      @(negedge clk); guard++;
      if (o_ready[1]) begin
        t_acc[nacc] = cyc;
        nacc++;
        @(posedge clk); #1;
        if (nacc == 1) tv_addr[1] = 32'h4;
        else tv_valid[1] = 1'b0;
      end
    end
    check("b2b accepts", 32'(nacc), 32'd2);
    check("b2b spacing", 32'(t_acc[1] - t_acc[0]), 32'd2);
    @(negedge clk);
    check("b2b second valid", 32'(o_valid[1]), 32'h1);
    check("b2b second rdata", o_rdata[1], 32'h5A5A_5A5A);
    @(posedge clk); #1 tv_rr[1] = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
